mac_accumulator: RTL and testbench
==================================

# mac_accumulator

Pipelined multiply-accumulate stage that sits directly downstream of the signed/unsigned multiplier. It accepts a stream of operand beats grouped into packets by a `last` flag, forms each 2n-bit product, and sums the products of a packet into a widened accumulator. It presents one result per packet (sum, beat count, sticky overflow) on a valid/ready output port. Both ports use valid/ready handshakes and support backpressure.

## Interface
- `n`, default 8: operand width.
- `guard`, default 8: accumulator guard bits; `acc_w = 2*n + guard`.
- `cnt_w`, default 16: beat-counter width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset; asynchronous, active-high.
- `up_valid`  in  1: an operand beat is offered.
- `up_ready`  out  1: the stage accepts the beat this cycle.
- `up_a`, `up_b`  in  n: operands.
- `up_signed`  in  1: 1 = two's-complement operands; sampled on a packet's first beat only.
- `up_last`  in  1: final beat of the packet.
- `down_valid`  out  1: packet result is available.
- `down_ready`  in  1: consumer takes the result.
- `down_sum`  out  acc_w: accumulated sum, modulo 2^acc_w.
- `down_count`  out  cnt_w: number of beats in the packet; saturates at all-ones.
- `down_ovf`  out  1: an accumulation overflow occurred in this packet.

## Operation
- Handshake: a transfer occurs when valid && ready. A valid signal, once raised, holds it and its data stable until the transfer. `up_ready` may depend combinationally on `down_ready`.
- Stage P (product register): on acceptance, register `p_valid=1`, the 2n-bit product of `up_a` and `up_b` (signed or unsigned per the packet mode), and `p_last`.
- Packet mode: latch `up_signed` on the first beat (state `IDLE`). Ignore `up_signed` on later beats (state `IN_PKT`). Return to `IDLE` when the last beat is accepted.
- Stage A (accumulator): consumes stage P.
  - Product extension to acc_w: signed mode sign-extends bit 2n-1; unsigned mode zero-extends.
  - First beat of a packet: `acc = ext`, `cnt = 1`, `ovf = 0`. Later beats: `acc = acc + ext`, `cnt` increments and saturates at all-ones.
  - `ovf` is sticky. In signed mode it sets on signed overflow of the acc_w add. In unsigned mode it sets on carry-out.
- Output register: when a product with `p_last=1` is consumed, copy the final acc, cnt and ovf into `down_*` and set `down_valid`. `down_valid` clears on a down transfer unless a new last beat loads in the same cycle; in that case the new result replaces the old one and `down_valid` stays high.
- Stall rule: `accept_p = p_valid && !(p_last && down_valid && !down_ready)`. `up_ready = !p_valid || accept_p`. Non-last beats keep accumulating while an earlier result waits.
- Reset: all valids 0, `up_ready` reads 1, acc, cnt, ovf and all `down_*` outputs 0, mode state `IDLE`. Reset during a packet discards the partial sum; the next accepted beat starts a fresh packet.

## Timing
- Latency: beat accepted at edge E0; product valid after E0; accumulated at E1. If the beat is last, `down_valid=1` after E1, a 2-edge latency.
- Throughput: one beat per cycle with no bubbles, including back-to-back packets (a new packet's first beat may sit in stage P while the previous packet's last beat is consumed).
- Single-beat packet: `down_sum` equals the extended product, `down_count=1`.
- Simultaneous events: a down transfer and a new last-beat load in one cycle gives a seamless result change.

## Structure
- Package `mac_pkg`: `typedef enum logic {IDLE, IN_PKT} mac_state_t`; a function `ext_product(p, is_signed)` that widens the product to acc_w; an overflow-detect helper.
- Sub-module: instantiate `signed_or_unsigned_mul` (n) for the product, registered in stage P.
- All other logic is flat in `mac_accumulator`.

## Test plan
- Unsigned packet, n=8: (255,255), (2,3), (1,1, last) -> `down_sum=65032`, `down_count=3`, `down_ovf=0`, `down_valid` 2 edges after the last acceptance.
- Signed packet: (-128,-128), (-1,5, last) -> `down_sum=0x003FFB` (16379). Single-beat signed (-3,4) -> `0xFFFFF4`, `down_count=1`.
- Mode latch: first beat unsigned (0xFF,0x02), second beat with `up_signed=1` (0xFF,0x01, last) -> `down_sum=765`.
- Overflow: 259 unsigned beats of (255,255) -> `down_ovf=1`, `down_sum=64259`, `down_count=259`.
- Backpressure: hold `down_ready=0` with packet A's result pending and stream packet B (3 beats). `up_ready` drops only while B's last beat sits in stage P. Raise `down_ready` -> A then B delivered in order, values intact.
- Reset mid-packet after 2 beats, then a 1-beat packet (7,6) -> `down_sum=42`, `down_count=1`. All outputs are 0 during reset.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and helpers for the multiply-accumulate stage
//
// Contents:
//   mac_state_t   packet-mode state (IDLE = expecting a first beat, IN_PKT = mid-packet)
//   EXT_MAX_W     widest accumulator the extension helper supports
//   ext_product   widen a p_w-bit product to EXT_MAX_W bits (sign- or zero-extend)
//   add_overflow  overflow of an add, signed (operand/result sign) or unsigned (carry-out)
package mac_pkg;

  typedef enum logic {IDLE, IN_PKT} mac_state_t;

  localparam int unsigned EXT_MAX_W = 64;

  // The product arrives zero-padded in the low p_w bits; the caller truncates
  // the result to its own accumulator width.
  function automatic logic [EXT_MAX_W-1:0] ext_product(
    input logic [EXT_MAX_W-1:0] p,
    input int unsigned          p_w,
    input logic                 is_signed
  );
    logic [EXT_MAX_W-1:0] hi_mask;
    logic                 sgn;
    hi_mask = {EXT_MAX_W{1'b1}} << p_w;
    sgn     = ((p >> (p_w - 1)) & {{(EXT_MAX_W-1){1'b0}}, 1'b1}) != '0;
    return (is_signed && sgn) ? (p | hi_mask) : (p & ~hi_mask);
  endfunction

  function automatic logic add_overflow(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb,
    input logic carry,
    input logic is_signed
  );
    return is_signed ? ((a_msb == b_msb) && (s_msb != a_msb)) : carry;
  endfunction

endpackage

// File: rtl/signed_or_unsigned_mul.sv
// rtl/signed_or_unsigned_mul.sv - combinational n x n multiplier, signed or unsigned
//
// Ports:
//   i_a, i_b   n-bit operands
//   i_signed   1 = treat operands as two's complement
//   o_p        2n-bit product
module signed_or_unsigned_mul #(
  parameter int unsigned n = 8
) (
  input  logic [n-1:0]   i_a,
  input  logic [n-1:0]   i_b,
  input  logic           i_signed,
  output logic [2*n-1:0] o_p
);

  logic [2*n-1:0] w_a_ext;
  logic [2*n-1:0] w_b_ext;

  // Extending both operands to 2n bits first makes the low 2n bits of a plain
  // multiply equal the signed product, so one multiplier serves both modes.
  assign w_a_ext = i_signed ? {{n{i_a[n-1]}}, i_a} : {{n{1'b0}}, i_a};
  assign w_b_ext = i_signed ? {{n{i_b[n-1]}}, i_b} : {{n{1'b0}}, i_b};
  assign o_p     = w_a_ext * w_b_ext;

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - pipelined multiply-accumulate over packets of operand beats
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   up_valid/up_ready         operand beat handshake
//   up_a, up_b                n-bit operands
//   up_signed                 operand mode, taken from the first beat of a packet
//   up_last                   final beat of the packet
//   down_valid/down_ready     packet result handshake
//   down_sum                  accumulated sum mod 2^(2n+guard)
//   down_count                beats in the packet, saturating
//   down_ovf                  sticky accumulation overflow for the packet
//
// Pipeline: stage P registers the product, stage A accumulates it, and a
// packet's last beat copies the totals into the output register.
// 2n+guard must not exceed mac_pkg::EXT_MAX_W.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned n     = 8,
  parameter int unsigned guard = 8,
  parameter int unsigned cnt_w = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   up_valid,
  output logic                   up_ready,
  input  logic [n-1:0]           up_a,
  input  logic [n-1:0]           up_b,
  input  logic                   up_signed,
  input  logic                   up_last,
  output logic                   down_valid,
  input  logic                   down_ready,
  output logic [2*n+guard-1:0]   down_sum,
  output logic [cnt_w-1:0]       down_count,
  output logic                   down_ovf
);

  localparam int unsigned PW    = 2 * n;
  localparam int unsigned acc_w = 2 * n + guard;

  mac_state_t        r_state;
  mac_state_t        w_state_next;
  logic              r_mode;
  logic              w_mode;
  logic              w_up_fire;
  logic              w_accept_p;

  logic [PW-1:0]     w_prod;
  logic [PW-1:0]     r_p;
  logic              r_p_valid;
  logic              r_p_last;
  logic              r_p_signed;
  logic              r_p_first;

  logic [acc_w-1:0]  r_acc;
  logic [cnt_w-1:0]  r_cnt;
  logic              r_ovf;
  logic [acc_w-1:0]  w_ext;
  logic [acc_w-1:0]  w_sum;
  logic              w_carry;
  logic              w_ovf_add;
  logic [acc_w-1:0]  w_acc_next;
  logic [cnt_w-1:0]  w_cnt_next;
  logic              w_ovf_next;

  logic              r_down_valid;
  logic [acc_w-1:0]  r_down_sum;
  logic [cnt_w-1:0]  r_down_count;
  logic              r_down_ovf;

  // A last beat may not leave stage P while an unconsumed result occupies the
  // output register; non-last beats never touch that register so they flow on.
  assign w_accept_p = r_p_valid && !(r_p_last && r_down_valid && !down_ready);
  assign up_ready   = !r_p_valid || w_accept_p;
  assign w_up_fire  = up_valid && up_ready;

  // On a packet's first beat the live up_signed picks the mode for that very product.
  assign w_mode = (r_state == IDLE) ? up_signed : r_mode;

  signed_or_unsigned_mul #(.n(n)) u_mul (
    .i_a      (up_a),
    .i_b      (up_b),
    .i_signed (w_mode),
    .o_p      (w_prod)
  );

  // Packet-mode FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_up_fire && (r_state == IDLE)) begin
        r_mode <= up_signed;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_up_fire) begin
      w_state_next = up_last ? IDLE : IN_PKT;
    end
  end

  // Stage P: product register. Mode and first-beat flag travel with the product
  // so stage A never looks back at the FSM, which may already be on the next packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_valid  <= 1'b0;
      r_p        <= '0;
      r_p_last   <= 1'b0;
      r_p_signed <= 1'b0;
      r_p_first  <= 1'b0;
    end else if (w_up_fire) begin
      r_p_valid  <= 1'b1;
      r_p        <= w_prod;
      r_p_last   <= up_last;
      r_p_signed <= w_mode;
      r_p_first  <= (r_state == IDLE);
    end else if (w_accept_p) begin
      r_p_valid  <= 1'b0;
    end
  end

  // Stage A: extension, add and overflow detection
  always_comb begin
    w_ext              = acc_w'(ext_product({{(EXT_MAX_W-PW){1'b0}}, r_p}, PW, r_p_signed));
    {w_carry, w_sum}   = {1'b0, r_acc} + {1'b0, w_ext};
    w_ovf_add          = add_overflow(r_acc[acc_w-1], w_ext[acc_w-1], w_sum[acc_w-1],
                                      w_carry, r_p_signed);
    w_acc_next         = w_sum;
    w_cnt_next         = (r_cnt == {cnt_w{1'b1}}) ? r_cnt : r_cnt + cnt_w'(1);
    w_ovf_next         = r_ovf | w_ovf_add;
    if (r_p_first) begin
      w_acc_next = w_ext;
      w_cnt_next = cnt_w'(1);
      w_ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept_p) begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_next;
      r_ovf <= w_ovf_next;
    end
  end

  // Output register: a new result load wins over the clear, so a transfer and
  // a load in the same cycle swap results with down_valid held high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_down_valid <= 1'b0;
      r_down_sum   <= '0;
      r_down_count <= '0;
      r_down_ovf   <= 1'b0;
    end else if (w_accept_p && r_p_last) begin
      r_down_valid <= 1'b1;
      r_down_sum   <= w_acc_next;
      r_down_count <= w_cnt_next;
      r_down_ovf   <= w_ovf_next;
    end else if (r_down_valid && down_ready) begin
      r_down_valid <= 1'b0;
    end
  end

  assign down_valid = r_down_valid;
  assign down_sum   = r_down_sum;
  assign down_count = r_down_count;
  assign down_ovf   = r_down_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - self-checking bench for mac_accumulator
module tb_mac_accumulator;

  localparam int    ACC_W = 24;
  localparam longint HALF = 64'sd8388608;
  localparam longint FULL = 64'sd16777216;

  logic              clk = 1'b0;
  logic              rst;
  logic              up_valid;
  logic              up_ready;
  logic [7:0]        up_a;
  logic [7:0]        up_b;
  logic              up_signed;
  logic              up_last;
  logic              down_valid;
  logic              down_ready;
  logic [ACC_W-1:0]  down_sum;
  logic [15:0]       down_count;
  logic              down_ovf;

  mac_accumulator #(.n(8), .guard(8), .cnt_w(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_a       (up_a),
    .up_b       (up_b),
    .up_signed  (up_signed),
    .up_last    (up_last),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_sum   (down_sum),
    .down_count (down_count),
    .down_ovf   (down_ovf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_delivered = 0;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [15:0]      cnt;
    logic             ovf;
  } res_t;

  res_t exp_q[$];

  // Packet model: true products summed with wrap-around at 2^24 (unsigned) or
  // into [-2^23, 2^23) (signed); leaving that range marks the packet overflowed.
  bit     m_in   = 1'b0;
  bit     m_mode = 1'b0;
  longint m_acc  = 0;
  int     m_cnt  = 0;
  bit     m_ovf  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input logic s, input logic last);
    longint pa, pb, p, sum;
    bit first;
    res_t r;
    first = !m_in;
    if (first) begin
      m_mode = s;
      m_in   = 1'b1;
    end
    pa = longint'(a);
    pb = longint'(b);
    if (m_mode) begin
      if (a[7]) pa = pa - 256;
      if (b[7]) pb = pb - 256;
    end
    p = pa * pb;
    if (first) begin
      m_acc = p;
      m_cnt = 1;
      m_ovf = 1'b0;
    end else begin
      sum = m_acc + p;
      if (m_mode) begin
        if (sum >= HALF) begin
          m_ovf = 1'b1;
          sum   = sum - FULL;
        end else if (sum < -HALF) begin
          m_ovf = 1'b1;
          sum   = sum + FULL;
        end
      end else if (sum >= FULL) begin
        m_ovf = 1'b1;
        sum   = sum - FULL;
      end
      m_acc = sum;
      if (m_cnt < 65535) m_cnt++;
    end
    if (last) begin
      r.sum = m_acc[ACC_W-1:0];
      r.cnt = m_cnt[15:0];
      r.ovf = m_ovf;
      exp_q.push_back(r);
      m_in = 1'b0;
    end
  endtask

  // Compare process: inputs are stable between negedge and the next posedge,
  // so a handshake seen here is the one the coming edge performs.
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      m_in = 1'b0;
      exp_q.delete();
      check("rst_down_valid", 64'(down_valid), 64'd0);
      check("rst_down_sum",   64'(down_sum),   64'd0);
      check("rst_down_count", 64'(down_count), 64'd0);
      check("rst_down_ovf",   64'(down_ovf),   64'd0);
      check("rst_up_ready",   64'(up_ready),   64'd1);
    end else begin
      if (down_valid && down_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got sum %0d with no result expected", down_sum);
        end else begin
          e = exp_q.pop_front();
          check("model_sum",   64'(down_sum),   64'(e.sum));
          check("model_count", 64'(down_count), 64'(e.cnt));
          check("model_ovf",   64'(down_ovf),   64'(e.ovf));
          n_delivered++;
        end
      end
      if (up_valid && up_ready) model_accept(up_a, up_b, up_signed, up_last);
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic last, output int waits);
    up_valid  = 1'b1;
    up_a      = a;
    up_b      = b;
    up_signed = s;
    up_last   = last;
    waits     = 0;
    while (1) begin
      @(negedge clk);
      if (up_ready === 1'b1) break;
      waits++;
      if (waits > 1000) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got up_ready %0d expected 1", up_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    up_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (down_valid !== 1'b1 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (down_valid !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got down_valid %0d expected 1", name, down_valid);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic       last;
  } beat_t;

  beat_t burst[] = '{
    '{8'd7,   8'd9,   1'b0, 1'b1},
    '{8'hFE,  8'h03,  1'b1, 1'b0},
    '{8'h10,  8'h10,  1'b1, 1'b1},
    '{8'h81,  8'h7F,  1'b1, 1'b1},
    '{8'd200, 8'd100, 1'b0, 1'b0},
    '{8'd50,  8'd50,  1'b0, 1'b1},
    '{8'hFF,  8'hFF,  1'b1, 1'b1}
  };

  initial begin
    int w, w0, w1, w2;
    rst        = 1'b1;
    up_valid   = 1'b0;
    up_a       = '0;
    up_b       = '0;
    up_signed  = 1'b0;
    up_last    = 1'b0;
    down_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Unsigned packet and 2-edge latency
    send(8'd255, 8'd255, 1'b0, 1'b0, w);
    send(8'd2,   8'd3,   1'b0, 1'b0, w);
    send(8'd1,   8'd1,   1'b0, 1'b1, w);
    check("lat_after_e0", 64'(down_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_after_e1", 64'(down_valid), 64'd1);
    check("unsigned_sum", 64'(down_sum),   64'd65032);
    check("unsigned_cnt", 64'(down_count), 64'd3);
    check("unsigned_ovf", 64'(down_ovf),   64'd0);
    @(posedge clk);
    #1;

    // Signed packet
    send(8'h80, 8'h80, 1'b1, 1'b0, w);
    send(8'hFF, 8'd5,  1'b1, 1'b1, w);
    wait_valid("signed");
    check("signed_sum", 64'(down_sum),   64'd16379);
    check("signed_cnt", 64'(down_count), 64'd2);
    @(posedge clk);
    #1;

    // Single-beat signed
    send(8'hFD, 8'd4, 1'b1, 1'b1, w);
    wait_valid("single");
    check("single_sum", 64'(down_sum),   64'hFFFFF4);
    check("single_cnt", 64'(down_count), 64'd1);
    @(posedge clk);
    #1;

    // Mode is latched on the first beat
    send(8'hFF, 8'h02, 1'b0, 1'b0, w);
    send(8'hFF, 8'h01, 1'b1, 1'b1, w);
    wait_valid("mode");
    check("mode_sum", 64'(down_sum), 64'd765);
    @(posedge clk);
    #1;

    // Unsigned overflow
    for (int i = 0; i < 259; i++) send(8'd255, 8'd255, 1'b0, (i == 258), w);
    wait_valid("uovf");
    check("uovf_flag", 64'(down_ovf),   64'd1);
    check("uovf_sum",  64'(down_sum),   64'd64259);
    check("uovf_cnt",  64'(down_count), 64'd259);
    @(posedge clk);
    #1;

    // Backpressure: A pending while B streams
    down_ready = 1'b0;
    send(8'd3, 8'd4, 1'b0, 1'b0, w);
    send(8'd5, 8'd6, 1'b0, 1'b1, w);
    wait_valid("bp_a");
    send(8'd1, 8'd2, 1'b0, 1'b0, w0);
    send(8'd3, 8'd4, 1'b0, 1'b0, w1);
    send(8'd5, 8'd6, 1'b0, 1'b1, w2);
    check("bp_b_stalls", 64'(w0 + w1 + w2), 64'd0);
    check("bp_ready_low", 64'(up_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_ready_held", 64'(up_ready), 64'd0);
    check("bp_a_valid",    64'(down_valid), 64'd1);
    check("bp_a_sum",      64'(down_sum),   64'd42);
    down_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_seamless_valid", 64'(down_valid), 64'd1);
    check("bp_b_sum",          64'(down_sum),   64'd44);
    check("bp_ready_back",     64'(up_ready),   64'd1);
    @(posedge clk);
    #1;

    // Back-to-back packets: no bubbles
    foreach (burst[i]) begin
      send(burst[i].a, burst[i].b, burst[i].s, burst[i].last, w);
      check("burst_no_stall", 64'(w), 64'd0);
    end

    // Signed overflow: 513 x (-128 * -128)
    for (int i = 0; i < 513; i++) send(8'h80, 8'h80, 1'b1, (i == 512), w);
    wait_valid("sovf");
    check("sovf_flag", 64'(down_ovf),   64'd1);
    check("sovf_sum",  64'(down_sum),   64'h804000);
    check("sovf_cnt",  64'(down_count), 64'd513);
    @(posedge clk);
    #1;

    // Reset mid-packet
    send(8'd1, 8'd1, 1'b0, 1'b0, w);
    send(8'd2, 8'd2, 1'b0, 1'b0, w);
    rst = 1'b1;
    #1;
    check("rst_async_sum",   64'(down_sum),   64'd0);
    check("rst_async_ready", 64'(up_ready),   64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'd7, 8'd6, 1'b0, 1'b1, w);
    wait_valid("post_rst");
    check("post_rst_sum", 64'(down_sum),   64'd42);
    check("post_rst_cnt", 64'(down_count), 64'd1);
    check("post_rst_ovf", 64'(down_ovf),   64'd0);

    repeat (3) @(posedge clk);
    #1;
    check("all_delivered", 64'(exp_q.size()), 64'd0);
    check("delivered_cnt", 64'(n_delivered),  64'd14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
